// File: rtl/fetch_pc.sv
// Instruction-fetch stage: PC, single-outstanding imem request,
// one-entry skid buffer to decode, redirect squash and HALT latch.
module fetch_pc #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        brTaken,
    input  logic [15:0] brTarget,
    input  logic        jump,
    input  logic [15:0] jumpTarget,
    input  logic        stall,
    input  logic        halt,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic        imemDone,
    input  logic [15:0] imemData,
    output logic [15:0] instr,
    output logic [15:0] pcPlus2,
    output logic        instrValid,
    output logic        halted
);

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HALTED
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] skidData;
    logic [15:0] skidPc2;
    logic        skidValid;
    logic        squash;

    logic        redirect;
    logic [15:0] target;
    logic [15:0] pcNext2;
    logic        free;
    logic        consume;
    logic        doHalt;
    logic        accept;

    // Once halted, redirects no longer steer the PC.
    assign redirect = (jump | brTaken) & ~halted;
    assign target   = jump ? jumpTarget : brTarget;
    assign pcNext2  = pc + 16'd2;
    assign free     = ~instrValid | ~stall;
    assign consume  = instrValid & ~stall;
    assign doHalt   = halt & consume & ~redirect & ~halted;
    assign accept   = (state == WAIT) & imemDone & ~squash;
    assign imemAddr = pc;

    assign imemReq = ~rst & (state == ISSUE) & ~halted & ~skidValid
                   & free & ~redirect & ~halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ISSUE;
            pc         <= RESET_PC;
            instr      <= NOP;
            pcPlus2    <= 16'h0000;
            instrValid <= 1'b0;
            halted     <= 1'b0;
            skidData   <= NOP;
            skidPc2    <= 16'h0000;
            skidValid  <= 1'b0;
            squash     <= 1'b0;
        end else if (halted) begin
            // Drain the squashed in-flight fetch before parking.
            if (state == WAIT && imemDone) begin
                state  <= HALTED;
                squash <= 1'b0;
            end
        end else if (redirect) begin
            pc         <= target;
            instrValid <= 1'b0;
            instr      <= NOP;
            skidValid  <= 1'b0;
            if (state == WAIT && !imemDone) begin
                squash <= 1'b1;
            end else begin
                squash <= 1'b0;
                state  <= ISSUE;
            end
        end else begin
            case (state)
                ISSUE: begin
                    if (doHalt)
                        state <= HALTED;
                    else if (imemReq)
                        state <= WAIT;
                end
                WAIT: begin
                    if (imemDone) begin
                        squash <= 1'b0;
                        state  <= doHalt ? HALTED : ISSUE;
                        if (accept && !doHalt)
                            pc <= pcNext2;
                    end else if (doHalt) begin
                        squash <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (doHalt) begin
                instrValid <= 1'b0;
                instr      <= NOP;
                halted     <= 1'b1;
                skidValid  <= 1'b0;
            end else if (skidValid && consume) begin
                instr     <= skidData;
                pcPlus2   <= skidPc2;
                skidValid <= 1'b0;
            end else if (accept) begin
                if (free) begin
                    instr      <= imemData;
                    pcPlus2    <= pcNext2;
                    instrValid <= 1'b1;
                end else begin
                    skidData  <= imemData;
                    skidPc2   <= pcNext2;
                    skidValid <= 1'b1;
                end
            end else if (consume) begin
                instrValid <= 1'b0;
                instr      <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc with a variable-latency memory model
// returning data = addr + 0x1000.
module tb_fetch_pc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        brTaken = 1'b0;
    logic [15:0] brTarget = 16'h0000;
    logic        jump = 1'b0;
    logic [15:0] jumpTarget = 16'h0000;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemDone = 1'b0;
    logic [15:0] imemData = 16'h0000;
    logic [15:0] instr;
    logic [15:0] pcPlus2;
    logic        instrValid;
    logic        halted;

    fetch_pc dut (
        .clk(clk),
        .rst(rst),
        .brTaken(brTaken),
        .brTarget(brTarget),
        .jump(jump),
        .jumpTarget(jumpTarget),
        .stall(stall),
        .halt(halt),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemDone(imemDone),
        .imemData(imemData),
        .instr(instr),
        .pcPlus2(pcPlus2),
        .instrValid(instrValid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sbq[$];
    logic [31:0] expEntry;
    int          lat = 1;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        jump    = 1'b0;
        brTaken = 1'b0;
        halt    = 1'b0;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    task automatic do_reset(input int l);
        tick;
        rst   = 1'b1;
        stall = 1'b0;
        tick;
        tick;
        lat = l;
        rst = 1'b0;
    endtask

    // Memory model: request seen mid-cycle, response lat cycles later.
    initial begin
        logic        cap;
        logic [15:0] ca;
        logic [15:0] maddr;
        logic        pending;
        int          cnt;
        pending = 1'b0;
        cnt     = 0;
        maddr   = 16'h0000;
        forever begin
            @(negedge clk);
            cap = imemReq;
            ca  = imemAddr;
            @(posedge clk);
            #1;
            imemDone = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imemDone = 1'b1;
                    imemData = maddr + 16'h1000;
                    pending  = 1'b0;
                end
            end
            if (cap) begin
                maddr = ca;
                cnt   = lat - 1;
                if (cnt == 0) begin
                    imemDone = 1'b1;
                    imemData = ca + 16'h1000;
                end else begin
                    pending = 1'b1;
                end
            end
        end
    end

    // Monitor: every instruction consumed by decode is checked.
    always @(negedge clk) begin
        if (!rst && instrValid && !stall) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got %h/%h expected none",
                         instr, pcPlus2);
            end else begin
                expEntry = sbq.pop_front();
                chk("sb_instr", instr, expEntry[31:16]);
                chk("sb_pcPlus2", pcPlus2, expEntry[15:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset values, 1-cycle memory.
        tick;
        tick;
        neg;
        chk("rst_req", {15'd0, imemReq}, 16'd0);
        chk("rst_instr", instr, 16'h0800);
        chk("rst_pcPlus2", pcPlus2, 16'h0000);
        chk("rst_valid", {15'd0, instrValid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_addr", imemAddr, 16'h0000);

        sbq.push_back({16'h1000, 16'h0002});
        sbq.push_back({16'h1002, 16'h0004});
        tick;
        rst = 1'b0;
        neg;
        chk("s1_req0", {15'd0, imemReq}, 16'd1);
        chk("s1_addr0", imemAddr, 16'h0000);
        tick; neg;
        chk("s1_req_gap1", {15'd0, imemReq}, 16'd0);
        tick; neg;
        chk("s1_req2", {15'd0, imemReq}, 16'd1);
        chk("s1_addr2", imemAddr, 16'h0002);
        tick; neg;
        chk("s1_req_gap3", {15'd0, imemReq}, 16'd0);
        tick; neg;
        chk("s1_req4", {15'd0, imemReq}, 16'd1);
        chk("s1_addr4", imemAddr, 16'h0004);
        tick;
        tick;
        stall = 1'b1;
        neg;
        chk("s1_held_instr", instr, 16'h1004);
        chk("s1_held_pc2", pcPlus2, 16'h0006);
        chk("s1_held_req", {15'd0, imemReq}, 16'd0);

        // 3-cycle memory with a 4-cycle stall over the response.
        do_reset(3);
        sbq.push_back({16'h1000, 16'h0002});
        sbq.push_back({16'h1002, 16'h0004});
        neg;
        chk("s2_addr0", imemAddr, 16'h0000);
        tick; tick; tick;
        tick; neg;
        chk("s2_req2", {15'd0, imemReq}, 16'd1);
        chk("s2_addr2", imemAddr, 16'h0002);
        tick;
        tick;
        stall = 1'b1;
        neg;
        chk("s2_stall_req_a", {15'd0, imemReq}, 16'd0);
        tick; neg;
        chk("s2_stall_req_b", {15'd0, imemReq}, 16'd0);
        tick; neg;
        chk("s2_stall_req_c", {15'd0, imemReq}, 16'd0);
        chk("s2_stall_instr", instr, 16'h1002);
        tick; neg;
        chk("s2_stall_req_d", {15'd0, imemReq}, 16'd0);
        chk("s2_stall_valid", {15'd0, instrValid}, 16'd1);
        tick;
        stall = 1'b0;
        neg;
        chk("s2_resume_req", {15'd0, imemReq}, 16'd1);
        chk("s2_resume_addr", imemAddr, 16'h0004);

        // Branch mid-fetch squashes the wrong-path response.
        do_reset(3);
        sbq.push_back({16'h1040, 16'h0042});
        jump       = 1'b1;
        jumpTarget = 16'h0010;
        neg;
        chk("s3_jump_req", {15'd0, imemReq}, 16'd0);
        tick; neg;
        chk("s3_req10", {15'd0, imemReq}, 16'd1);
        chk("s3_addr10", imemAddr, 16'h0010);
        tick;
        brTaken  = 1'b1;
        brTarget = 16'h0040;
        neg;
        chk("s3_br_req", {15'd0, imemReq}, 16'd0);
        tick; neg;
        chk("s3_valid_after", {15'd0, instrValid}, 16'd0);
        chk("s3_addr40", imemAddr, 16'h0040);
        chk("s3_wait_req", {15'd0, imemReq}, 16'd0);
        tick; neg;
        chk("s3_squash_valid", {15'd0, instrValid}, 16'd0);
        chk("s3_squash_req", {15'd0, imemReq}, 16'd0);
        tick; neg;
        chk("s3_req40", {15'd0, imemReq}, 16'd1);
        chk("s3_req40_addr", imemAddr, 16'h0040);
        tick; tick; tick;
        tick; neg;
        chk("s3_tgt_valid", {15'd0, instrValid}, 16'd1);

        // Jump beats branch; then HALT.
        do_reset(1);
        sbq.push_back({16'h1100, 16'h0102});
        jump       = 1'b1;
        jumpTarget = 16'h0100;
        brTaken    = 1'b1;
        brTarget   = 16'h0200;
        neg;
        tick; neg;
        chk("s4_req", {15'd0, imemReq}, 16'd1);
        chk("s4_addr", imemAddr, 16'h0100);
        tick;
        tick;
        halt = 1'b1;
        neg;
        chk("s5_halt_req", {15'd0, imemReq}, 16'd0);
        chk("s5_halt_valid", {15'd0, instrValid}, 16'd1);
        tick; neg;
        chk("s5_halted", {15'd0, halted}, 16'd1);
        chk("s5_valid", {15'd0, instrValid}, 16'd0);
        chk("s5_nop", instr, 16'h0800);
        for (int i = 0; i < 20; i++) begin
            tick; neg;
            chk("s5_idle_req", {15'd0, imemReq}, 16'd0);
        end

        // Reset resumes at 0; then PC wrap at 0xFFFE.
        do_reset(1);
        sbq.push_back({16'h1000, 16'h0002});
        sbq.push_back({16'h0FFE, 16'h0000});
        neg;
        chk("s6_halted", {15'd0, halted}, 16'd0);
        chk("s6_req0", {15'd0, imemReq}, 16'd1);
        chk("s6_addr0", imemAddr, 16'h0000);
        tick;
        tick;
        jump       = 1'b1;
        jumpTarget = 16'hFFFE;
        tick; neg;
        chk("s6_reqFFFE", {15'd0, imemReq}, 16'd1);
        chk("s6_addrFFFE", imemAddr, 16'hFFFE);
        tick;
        tick; neg;
        chk("s6_wrap_pc2", pcPlus2, 16'h0000);
        chk("s6_wrap_instr", instr, 16'h0FFE);
        chk("s6_wrap_req", {15'd0, imemReq}, 16'd1);
        chk("s6_wrap_addr", imemAddr, 16'h0000);
        tick;
        tick;
        stall = 1'b1;
        neg;
        chk("s6_next_instr", instr, 16'h1000);
        chk("s6_next_pc2", pcPlus2, 16'h0002);
        tick;
        tick;
        neg;

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
